rexnor_rr_sched: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit reduction-XNOR (parity-complement) unit among NREQ requesters.
- Each requester presents a data word with a valid/ready handshake. The block grants one requester per cycle and evaluates ~^data on the shared unit.
- The result is returned through a single registered, back-pressurable response port, tagged with the requester ID.
- It sits between pattern sources (test benches, pattern generators) and the shared parity datapath. It also keeps a saturating count of zero-parity results for reporting.

---
 rtl/rexnor_rr_sched.sv | 153 +++++++++++++++
 tb/tb_rexnor_rr_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rexnor_rr_sched.sv
// ---------------------------------------------------------------------------
// rexnor_rr_sched
//   Round-robin scheduler sharing one WIDTH-bit reduction-XNOR unit among
//   NREQ requesters. One word is granted per cycle. The result goes into a
//   single registered, back-pressurable response slot, tagged with the
//   requester index. A saturating counter tracks results whose XNOR is 0.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]        per-requester word pending
//   req_data   : [NREQ*WIDTH]  word i in bits [i*WIDTH +: WIDTH]
//   req_ready  : [NREQ]        one-hot (or zero) accept strobe
//   rsp_valid  : response slot holds a result
//   rsp_ready  : consumer takes the response
//   rsp_id     : [IDW]   requester the result belongs to
//   rsp_xnor   : ~^ of the granted word
//   rsp_data   : [WIDTH] copy of the granted word
//   zero_cnt   : [CNTW]  saturating count of accepted words with xnor == 0
//   busy       : response pending or any request pending
// ---------------------------------------------------------------------------
module rexnor_rr_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2,
   parameter int CNTW  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_xnor,
   output logic [WIDTH-1:0]        rsp_data,
   output logic [CNTW-1:0]         zero_cnt,
   output logic                    busy
);

   // Shared parity-complement unit.
   function automatic logic xnor_reduce(input logic [WIDTH-1:0] d);
      return ~^d;
   endfunction

   logic [IDW-1:0]   ptr_r;
   logic             rsp_valid_r;
   logic [IDW-1:0]   rsp_id_r;
   logic             rsp_xnor_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic [CNTW-1:0]  zero_cnt_r;

   logic [NREQ-1:0]  win_s;
   logic [IDW-1:0]   gnt_s;
   logic             found_s;
   logic [IDW:0]     idx_s;
   logic [WIDTH-1:0] gnt_data_s;
   logic             gnt_xnor_s;
   logic             can_load_s;
   logic             accept_s;
   logic [IDW-1:0]   ptr_next_s;

   // Rotating priority search: start at ptr, walk upward with wrap, first valid wins.
   always_comb begin
      win_s   = '0;
      gnt_s   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
         // ptr is always < NREQ, so a single subtraction completes the wrap.
         if (idx_s >= (IDW+1)'(NREQ)) begin
            idx_s = idx_s - (IDW+1)'(NREQ);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_valid[idx_s[IDW-1:0]]) begin
            found_s                  = 1'b1;
            gnt_s                    = idx_s[IDW-1:0];
            win_s[idx_s[IDW-1:0]]    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Select the granted word for the shared XNOR unit.
   always_comb begin
      gnt_data_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_s == IDW'(k)) begin
            gnt_data_s = req_data[k*WIDTH +: WIDTH];
         end else begin
            gnt_data_s = gnt_data_s;
         end
      end
   end

   // Handshake qualification and next round-robin pointer.
   always_comb begin
      gnt_xnor_s = xnor_reduce(gnt_data_s);
      can_load_s = ~rsp_valid_r | rsp_ready;
      // req_ready is held low while reset is asserted.
      accept_s   = found_s & can_load_s & rst_n;
      req_ready  = accept_s ? win_s : '0;
      if (gnt_s == IDW'(NREQ-1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = gnt_s + IDW'(1);
      end
   end

   // Response slot, round-robin pointer and saturating zero-parity counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r       <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_xnor_r  <= 1'b0;
         rsp_data_r  <= '0;
         zero_cnt_r  <= '0;
      end else if (accept_s) begin
         // Accept overwrites the slot even if it is being consumed this cycle.
         ptr_r       <= ptr_next_s;
         rsp_valid_r <= 1'b1;
         rsp_id_r    <= gnt_s;
         rsp_xnor_r  <= gnt_xnor_s;
         rsp_data_r  <= gnt_data_s;
         if (!gnt_xnor_s && (zero_cnt_r != {CNTW{1'b1}})) begin
            zero_cnt_r <= zero_cnt_r + CNTW'(1);
         end else begin
            zero_cnt_r <= zero_cnt_r;
         end
      end else if (rsp_ready) begin
         // Consumed with nothing new: drop valid, keep the other fields.
         rsp_valid_r <= 1'b0;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end

   // Registered response outputs; busy is a plain status OR.
   always_comb begin
      rsp_valid = rsp_valid_r;
      rsp_id    = rsp_id_r;
      rsp_xnor  = rsp_xnor_r;
      rsp_data  = rsp_data_r;
      zero_cnt  = zero_cnt_r;
      busy      = rsp_valid_r | (|req_valid);
   end

endmodule

// File: tb/tb_rexnor_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_rexnor_rr_sched
//   Directed self-checking bench for rexnor_rr_sched. A second instance with
//   CNTW=2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_rexnor_rr_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_xnor;
   logic [7:0]  rsp_data;
   logic [15:0] zero_cnt;
   logic        busy;

   logic [3:0]  v2;
   logic [31:0] d2;
   logic [3:0]  rdy2;
   logic        rv2;
   logic        rr2;
   logic [1:0]  id2;
   logic        x2;
   logic [7:0]  rd2;
   logic [1:0]  cnt2;
   logic        busy2;

   int checks;
   int failures;

   rexnor_rr_sched #(.NREQ(4), .WIDTH(8), .IDW(2), .CNTW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_xnor(rsp_xnor), .rsp_data(rsp_data),
      .zero_cnt(zero_cnt), .busy(busy)
   );

   rexnor_rr_sched #(.NREQ(4), .WIDTH(8), .IDW(2), .CNTW(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_data(d2),
      .req_ready(rdy2), .rsp_valid(rv2), .rsp_ready(rr2),
      .rsp_id(id2), .rsp_xnor(x2), .rsp_data(rd2),
      .zero_cnt(cnt2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 4'b0000;
      req_data  = 32'h0;
      rsp_ready = 1'b1;
      v2        = 4'b0000;
      d2        = 32'h0;
      rr2       = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
      checks++; if (rsp_xnor !== 1'b0) begin failures++; $display("FAIL reset_rsp_xnor got=%b exp=0", rsp_xnor); end
      checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
      checks++; if (zero_cnt !== 16'd0) begin failures++; $display("FAIL reset_zero_cnt got=%0d exp=0", zero_cnt); end
      req_valid = 4'b0000;
      rst_n     = 1'b1;
      #1;
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0000;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got=%b exp=0001", req_ready); end
      cycle();
      req_valid = 4'b0000;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
      checks++; if (rsp_xnor !== 1'b1) begin failures++; $display("FAIL single_rsp_xnor got=%b exp=1", rsp_xnor); end
      checks++; if (zero_cnt !== 16'd0) begin failures++; $display("FAIL single_zero_cnt got=%0d exp=0", zero_cnt); end
      cycle();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_xnor !== 1'b1) begin failures++; $display("FAIL drain_hold_xnor got=%b exp=1", rsp_xnor); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy got=%b exp=0", busy); end
   endtask

   // Continues from test_single: ptr is 1, requester 2 alone still wins.
   task automatic test_parity();
      req_valid = 4'b0100;
      req_data  = 32'h0007_0000;
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL parity_req_ready got=%b exp=0100", req_ready); end
      cycle();
      checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL parity07_id got=%0d exp=2", rsp_id); end
      checks++; if (rsp_xnor !== 1'b0) begin failures++; $display("FAIL parity07_xnor got=%b exp=0", rsp_xnor); end
      checks++; if (rsp_data !== 8'h07) begin failures++; $display("FAIL parity07_data got=%h exp=07", rsp_data); end
      checks++; if (zero_cnt !== 16'd1) begin failures++; $display("FAIL parity07_cnt got=%0d exp=1", zero_cnt); end
      req_data = 32'h00FF_0000;
      cycle();
      req_valid = 4'b0000;
      checks++; if (rsp_xnor !== 1'b1) begin failures++; $display("FAIL parityFF_xnor got=%b exp=1", rsp_xnor); end
      checks++; if (rsp_data !== 8'hFF) begin failures++; $display("FAIL parityFF_data got=%h exp=ff", rsp_data); end
      checks++; if (zero_cnt !== 16'd1) begin failures++; $display("FAIL parityFF_cnt got=%0d exp=1", zero_cnt); end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_id [6];
      logic [7:0] exp_dat [4];
      logic [3:0] exp_rdy;
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_dat = '{8'h00, 8'h01, 8'h03, 8'h07};
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'h0703_0100;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         exp_rdy = 4'b0001 << exp_id[k];
         checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL b2b_req_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
         cycle();
         checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp_valid[%0d] got=%b exp=1", k, rsp_valid); end
         checks++; if (rsp_id !== exp_id[k]) begin failures++; $display("FAIL b2b_rsp_id[%0d] got=%0d exp=%0d", k, rsp_id, exp_id[k]); end
         checks++; if (rsp_data !== exp_dat[exp_id[k]]) begin failures++; $display("FAIL b2b_rsp_data[%0d] got=%h exp=%h", k, rsp_data, exp_dat[exp_id[k]]); end
      end
      req_valid = 4'b0000;
      // Words from requesters 1 and 3 have odd popcount: grants 1,3,1 count.
      checks++; if (zero_cnt !== 16'd3) begin failures++; $display("FAIL b2b_zero_cnt got=%0d exp=3", zero_cnt); end
      cycle();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 4'b1010;
      req_data  = 32'hC300_5A00;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%b exp=0010", req_ready); end
      cycle();
      checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL bp_first_id got=%0d exp=1", rsp_id); end
      rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0000", req_ready); end
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", k, rsp_valid); end
         checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL bp_hold_id[%0d] got=%0d exp=1", k, rsp_id); end
         checks++; if (rsp_data !== 8'h5A) begin failures++; $display("FAIL bp_hold_data[%0d] got=%h exp=5a", k, rsp_data); end
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0000", k, req_ready); end
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
      cycle();
      checks++; if (rsp_id !== 2'd3) begin failures++; $display("FAIL bp_release_id3 got=%0d exp=3", rsp_id); end
      checks++; if (rsp_data !== 8'hC3) begin failures++; $display("FAIL bp_release_data3 got=%h exp=c3", rsp_data); end
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_ready got=%b exp=0010", req_ready); end
      cycle();
      req_valid = 4'b0000;
      checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL bp_release_id1 got=%0d exp=1", rsp_id); end
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", rsp_valid); end
      cycle();
   endtask

   task automatic test_reset_midop();
      do_reset();
      req_valid = 4'b0100;
      req_data  = 32'h0007_0000;
      rsp_ready = 1'b0;
      cycle();
      req_valid = 4'b0000;
      checks++; if ((rsp_valid !== 1'b1) || (zero_cnt !== 16'd1)) begin failures++; $display("FAIL midop_setup got_valid=%b got_cnt=%0d exp_valid=1 exp_cnt=1", rsp_valid, zero_cnt); end
      #1;
      req_valid = 4'b1111;
      rst_n     = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midop_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (zero_cnt !== 16'd0) begin failures++; $display("FAIL midop_zero_cnt got=%0d exp=0", zero_cnt); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL midop_req_ready got=%b exp=0000", req_ready); end
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midop_prio_ready got=%b exp=0001", req_ready); end
      cycle();
      req_valid = 4'b0000;
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL midop_prio_id got=%0d exp=0", rsp_id); end
      cycle();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [4];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
      do_reset();
      v2  = 4'b0001;
      d2  = 32'h0000_0001;
      rr2 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         checks++; if (cnt2 !== exp_cnt[k]) begin failures++; $display("FAIL sat_zero_cnt[%0d] got=%0d exp=%0d", k, cnt2, exp_cnt[k]); end
      end
      v2 = 4'b0000;
      cycle();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b1;
      req_valid = 4'b0000;
      req_data  = 32'h0;
      rsp_ready = 1'b1;
      v2        = 4'b0000;
      d2        = 32'h0;
      rr2       = 1'b1;
      #2;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
